// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request/write/clear bundle between requesters, arbiter and register file
interface regfile_write_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          sweep;
  logic          gnt0;
  logic          gnt1;
  logic          we_n;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          ce_n;
  logic [AW-1:0] caddr;
  logic          busy;
  logic          done;

  modport master (
    output req0, req1, addr0, addr1, data0, data1, sweep,
    input  gnt0, gnt1, we_n, waddr, wdata, ce_n, caddr, busy, done
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1, sweep,
    output gnt0, gnt1, we_n, waddr, wdata, ce_n, caddr, busy, done
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin write-port arbiter with full-file clear sweep
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  regfile_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SWEEP} state_e;

  localparam logic [AW-1:0] CMAX = '1;

  state_e        state_q;
  logic          last_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          we_n_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          ce_n_q;
  logic [AW-1:0] caddr_q;
  logic          busy_q;
  logic          done_q;

  logic          any_req;
  logic          pick_d;
  logic          issue_d;

  assign any_req = bus.req0 | bus.req1;

  // Requests are evaluated both in IDLE and on the sweep-exit edge, so a
  // requester stalled by a sweep is granted on the very edge the sweep ends.
  always_comb begin
    pick_d  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    issue_d = 1'b0;
    if (any_req) begin
      if (state_q == S_IDLE && !bus.sweep)
        issue_d = 1'b1;
      else if (state_q == S_SWEEP && caddr_q == CMAX)
        issue_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_n_q  <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      ce_n_q  <= 1'b1;
      caddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      we_n_q <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.sweep) begin
            state_q <= S_SWEEP;
            ce_n_q  <= 1'b0;
            caddr_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
        end
        S_SWEEP: begin
          if (caddr_q == CMAX) begin
            state_q <= S_IDLE;
            ce_n_q  <= 1'b1;
            caddr_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            caddr_q <= caddr_q + 1'b1;
            done_q  <= (caddr_q == CMAX - 1'b1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (issue_d) begin
        state_q <= S_WRITE;
        we_n_q  <= 1'b0;
        waddr_q <= pick_d ? bus.addr1 : bus.addr0;
        wdata_q <= pick_d ? bus.data1 : bus.data0;
        gnt0_q  <= ~pick_d;
        gnt1_q  <= pick_d;
        last_q  <= pick_d;
      end
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.we_n  = we_n_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.ce_n  = ce_n_q;
  assign bus.caddr = caddr_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Controller that owns the register file's single write port and its clear port. It round-robin arbitrates write requests from two requesters (0: ALU writeback, 1: load/PC update) and sequences a full-file clear sweep on command. Outputs are registered on the rising edge of CLK so the register file, which captures on the falling edge, sees stable select/data/strobe for half a cycle.

## Interface
- DW, 32, data width of a register
- AW, 4, register address width; file depth is 2**AW (16)
- CLK  in  1  clock; all state updates on posedge
- CLR  in  1  reset, asynchronous, active-low
- REQ0, REQ1  in  1  write request, level; held with address/data until the matching GNT is seen
- ADDR0, ADDR1  in  AW  destination register of requester 0 / 1
- DATA0, DATA1  in  DW  write data of requester 0 / 1
- SWEEP  in  1  clear-all command, level, sampled only in IDLE
- GNT0, GNT1  out  1  one-cycle grant pulse, coincident with the issued write
- WE_N  out  1  active-low write strobe to the file's write-enable decoder
- WADDR  out  AW  write register select
- WDATA  out  DW  write data
- CE_N  out  1  active-low clear strobe to the file's clear decoder
- CADDR  out  AW  clear register select
- BUSY  out  1  high while a sweep is in progress
- DONE  out  1  one-cycle pulse on the last sweep cycle

## Operation
- FSM states: IDLE, WRITE, SWEEP.
- IDLE: evaluate in priority order:
  - SWEEP=1 -> SWEEP; CADDR=0, CE_N=0, BUSY=1.
  - exactly one REQ -> WRITE, grant that requester.
  - both REQ -> WRITE, grant the requester not equal to LAST; LAST is a 1-bit pointer to the most recently granted requester, reset value 1 (so requester 0 wins first tie).
  - none -> stay IDLE, all strobes inactive.
- Entering WRITE for requester k: WE_N=0, WADDR=ADDRk, WDATA=DATAk, GNTk=1, LAST=k. All registered together.
- WRITE: lasts exactly one cycle, unconditionally returns to IDLE; WE_N=1, GNTk=0. This is the turnaround cycle in which the requester drops or changes REQ; REQ is not sampled in WRITE.
- SWEEP: CE_N=0 each cycle, CADDR increments by 1 each cycle from 0 to 2**AW-1 (no wrap; no skipping). On the cycle CADDR=2**AW-1 is presented, DONE=1. Next edge -> IDLE, CE_N=1, BUSY=0, DONE=0, CADDR=0.
- During SWEEP, REQ0/REQ1 are ignored (no grants); requesters stall holding REQ. SWEEP input is ignored until IDLE is re-entered; a still-high SWEEP in IDLE starts a new sweep (level semantics).
- WE_N and CE_N are never low in the same cycle.
- WADDR/WDATA hold their last issued values when WE_N=1; CADDR is 0 outside SWEEP.
- LAST is unchanged by sweeps.

## Timing
- Reset (CLR=0, asynchronous, immediate): state IDLE, LAST=1, GNT0=GNT1=0, WE_N=1, WADDR=0, WDATA=0, CE_N=1, CADDR=0, BUSY=0, DONE=0. A sweep or write in progress is aborted; the strobe deasserts without waiting for a clock edge. Release of CLR is sampled at the next posedge.
- Request-to-write latency: REQ high before posedge N (in IDLE) -> WE_N low and GNT high from posedge N to N+1; file captures at the negedge inside that cycle.
- Write throughput: at most one write every 2 cycles; two continuously requesting masters alternate, each getting one write per 4 cycles.
- Sweep: SWEEP seen at posedge N -> CE_N low for cycles N..N+15 with CADDR=0..15; DONE high during cycle N+15; IDLE at posedge N+16. Earliest next grant at posedge N+16.
- All outputs are registers; no combinational input-to-output path.

## Test plan
- Reset: drive CLR=0 mid-cycle with REQ0=1 -> all outputs at reset values immediately; after release, first posedge grants requester 0 (GNT0=1, WE_N=0).
- Single write: REQ0=1, ADDR0=5, DATA0=0xDEADBEEF -> next posedge WE_N=0, WADDR=5, WDATA=0xDEADBEEF, GNT0=1 for exactly one cycle; following cycle WE_N=1.
- Round-robin: REQ0=REQ1=1 held continuously, ADDR0=1, ADDR1=2 -> grant sequence 0,1,0,1 at posedges 1,3,5,7; never two grants in consecutive cycles.
- Sweep: SWEEP pulse in IDLE -> 16 cycles CE_N=0 with CADDR 0..15, BUSY=1 throughout, DONE=1 only with CADDR=15; then IDLE.
- Sweep vs write: SWEEP=1 and REQ1=1 in the same IDLE cycle -> sweep wins; GNT1 issued at sweep-exit posedge (cycle 16 after start); WE_N and CE_N never simultaneously 0.
- Reset mid-sweep: CLR=0 at CADDR=7 -> CE_N=1, BUSY=0, CADDR=0 immediately; no DONE pulse; after release returns to normal IDLE arbitration.
